// File: rtl/dct_pkg.sv
// Shared definitions for the streaming 2-D DCT: FSM states, the fixed-point
// cosine table generator and the post-accumulation round/saturate step.
package dct_pkg;

    typedef enum logic {
        ST_ROW = 1'b0,
        ST_COL = 1'b1
    } dct_state_t;

    // Working width of the round/saturate helper; wide enough for any legal
    // accumulator (DATA_WIDTH + coefficient width + log2(N)).
    localparam int RS_W = 128;

    // C[u][x] = a(u)*cos((2x+1)*u*pi/(2N)) scaled by 2^frac, rounded half away
    // from zero. Evaluated at elaboration only, to build constant tables.
    function automatic int dct_coef(input int n, input int frac, input int u, input int x);
        real pi;
        real a;
        real v;
        pi = 3.14159265358979323846;
        a  = (u == 0) ? $sqrt(1.0 / real'(n)) : $sqrt(2.0 / real'(n));
        v  = a * $cos(real'((2 * x + 1) * u) * pi / (2.0 * real'(n)))
               * real'(longint'(1) << frac);
        if (v >= 0.0)
            return int'($floor(v + 0.5));
        else
            return -int'($floor(-v + 0.5));
    endfunction

    // Add half an LSB, arithmetic shift right by frac, clamp to signed dw bits.
    // Result is sign-extended to RS_W; callers keep the low dw bits.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] acc,
        input int                     frac,
        input int                     dw
    );
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] t;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        one = {{(RS_W-1){1'b0}}, 1'b1};
        if (frac > 0)
            t = (acc + (one <<< (frac - 1))) >>> frac;
        else
            t = acc;
        hi = (one <<< (dw - 1)) - one;
        lo = -(one <<< (dw - 1));
        if (t > hi)
            return hi;
        else if (t < lo)
            return lo;
        else
            return t;
    endfunction

endpackage

// File: rtl/dct_1d_lane.sv
// N-point matrix-vector product out[k] = sum_j in[j]*M[k][j], where M is the
// cosine table (forward) or its transpose (inverse). Purely combinational;
// the top shares this single instance between the row and column passes.
module dct_1d_lane
    import dct_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int COEF_FRAC  = 14
) (
    input  logic                    i_mode,
    input  logic [N*DATA_WIDTH-1:0] i_vec,
    output logic [N*DATA_WIDTH-1:0] o_vec
);

    // Coefficients never exceed sqrt(2/N)*2^COEF_FRAC < 2^COEF_FRAC, so a
    // sign bit plus one guard bit is enough.
    localparam int CW    = COEF_FRAC + 2;
    localparam int ACC_W = DATA_WIDTH + CW + $clog2(N);

    logic signed [CW-1:0] w_m [N][N];

    for (genvar k = 0; k < N; k++) begin : g_mk
        for (genvar j = 0; j < N; j++) begin : g_mj
            localparam int C_FWD = dct_coef(N, COEF_FRAC, k, j);
            localparam int C_INV = dct_coef(N, COEF_FRAC, j, k);
            assign w_m[k][j] = i_mode ? CW'(C_INV) : CW'(C_FWD);
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        logic signed [ACC_W-1:0] w_acc;

        // Full-precision dot product of the input vector with row k of M
        always_comb begin
            w_acc = '0;
            for (int jj = 0; jj < N; jj++) begin
                w_acc = w_acc
                      + ACC_W'($signed(i_vec[jj*DATA_WIDTH +: DATA_WIDTH]))
                      * ACC_W'(w_m[k][jj]);
            end
        end

        assign o_vec[k*DATA_WIDTH +: DATA_WIDTH] =
            DATA_WIDTH'(round_sat(RS_W'(w_acc), COEF_FRAC, DATA_WIDTH));
    end

endmodule

// File: rtl/dct_2d_nxn_stream.sv
// Streaming NxN 2-D DCT/IDCT. Rows arrive one per handshake and are pushed
// through the 1-D lane into a transpose buffer; once the block is complete
// the buffer is read column by column through the same lane and each result
// is presented as one output beat. One frame in flight at a time.
module dct_2d_nxn_stream
    import dct_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int COEF_FRAC  = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] in_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*DATA_WIDTH-1:0] out_col,
    output logic                    out_last
);

    localparam int RW  = $clog2(N);
    localparam int CW1 = RW + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);
    localparam logic [CW1-1:0] LAST_COL = CW1'(N - 1);
    localparam logic [CW1-1:0] NUM_COL  = CW1'(N);

    dct_state_t r_state;
    dct_state_t w_state_nxt;

    logic [RW-1:0]           r_row;      // next buffer row to write
    logic [CW1-1:0]          r_col;      // columns already loaded into out_col
    logic                    r_mode;     // mode latched for the current frame
    logic [N*DATA_WIDTH-1:0] r_buf [N];  // transpose buffer, r_buf[row] lane = column
    logic                    r_out_valid;
    logic                    r_out_last;
    logic [N*DATA_WIDTH-1:0] r_out_col;

    logic                    w_in_hs;
    logic                    w_out_hs;
    logic                    w_load;
    logic                    w_lane_mode;
    logic [RW-1:0]           w_kidx;
    logic [N*DATA_WIDTH-1:0] w_col_vec;
    logic [N*DATA_WIDTH-1:0] w_lane_in;
    logic [N*DATA_WIDTH-1:0] w_lane_out;

    assign in_ready  = (r_state == ST_ROW) && !reset;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_col   = r_out_col;

    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;
    // A new column is registered when the output slot is empty or being
    // drained this cycle, so accepted beats can follow back to back.
    assign w_load   = (r_state == ST_COL) && (r_col != NUM_COL)
                   && (!r_out_valid || out_ready);

    assign w_kidx = r_col[RW-1:0];
    for (genvar j = 0; j < N; j++) begin : g_colsel
        assign w_col_vec[j*DATA_WIDTH +: DATA_WIDTH] =
            r_buf[j][w_kidx*DATA_WIDTH +: DATA_WIDTH];
    end

    // The first row of a frame uses the live mode input since the latch
    // only captures it on that same edge.
    assign w_lane_mode = (r_state == ST_ROW && r_row == '0) ? mode : r_mode;
    assign w_lane_in   = (r_state == ST_ROW) ? in_row : w_col_vec;

    dct_1d_lane #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_FRAC  (COEF_FRAC)
    ) u_lane (
        .i_mode (w_lane_mode),
        .i_vec  (w_lane_in),
        .o_vec  (w_lane_out)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_ROW;
        else
            r_state <= w_state_nxt;
    end

    // Next state: leave ROW after the last row, leave COL after the last beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ROW: if (w_in_hs && r_row == LAST_ROW) w_state_nxt = ST_COL;
            ST_COL: if (w_out_hs && r_out_last)      w_state_nxt = ST_ROW;
            default: w_state_nxt = ST_ROW;
        endcase
    end

    // Row pass: write the transformed row into the transpose buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row  <= '0;
            r_mode <= 1'b0;
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
        end else if (w_in_hs) begin
            r_buf[r_row] <= w_lane_out;
            if (r_row == '0) r_mode <= mode;
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
        end
    end

    // Column pass: register each transformed column as one output beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_col   <= '0;
        end else if (w_load) begin
            r_out_col   <= w_lane_out;
            r_out_valid <= 1'b1;
            r_out_last  <= (r_col == LAST_COL);
            r_col       <= r_col + 1'b1;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) r_col <= '0;
        end
    end

endmodule

// File: tb/tb_dct_2d_nxn_stream.sv
// Directed bench for dct_2d_nxn_stream (N=8, 32-bit lanes, 14 fractional bits).
module tb_dct_2d_nxn_stream;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int CF = 14;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [N*DW-1:0] in_row;
    logic          out_valid;
    logic          out_ready;
    logic [N*DW-1:0] out_col;
    logic          out_last;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cf   [N][N];
    longint xin  [N][N];
    longint ymod [N][N];
    longint yout [N][N];
    longint orig [N][N];

    dct_2d_nxn_stream #(.N(N), .DATA_WIDTH(DW), .COEF_FRAC(CF)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_coefs;
        real a, v;
        for (int u = 0; u < N; u++)
            for (int x = 0; x < N; x++) begin
                a = (u == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
                v = a * $cos(3.14159265358979 * (2 * x + 1) * u / (2.0 * N)) * 16384.0;
                cf[u][x] = (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
            end
    endtask

    function automatic longint rs(input longint acc);
        longint t;
        t = (acc + 8192) >>> 14;
        if (t > SMAX) return SMAX;
        if (t < SMIN) return SMIN;
        return t;
    endfunction

    function automatic longint mc(input logic md, input int k, input int j);
        return md ? cf[j][k] : cf[k][j];
    endfunction

    // Golden 2-D transform of xin into ymod (row pass then column pass)
    task automatic model(input logic md);
        longint t [N][N];
        longint acc;
        for (int r = 0; r < N; r++)
            for (int k = 0; k < N; k++) begin
                acc = 0;
                for (int j = 0; j < N; j++) acc += xin[r][j] * mc(md, k, j);
                t[r][k] = rs(acc);
            end
        for (int k = 0; k < N; k++)
            for (int u = 0; u < N; u++) begin
                acc = 0;
                for (int j = 0; j < N; j++) acc += t[j][k] * mc(md, u, j);
                ymod[u][k] = rs(acc);
            end
    endtask

    // Called at a negedge; sends nrows rows of xin, returns at the negedge after the last handshake
    task automatic send_rows(input logic md, input logic flip, input int nrows);
        int n;
        for (int r = 0; r < nrows; r++) begin
            for (int x = 0; x < N; x++) in_row[x*DW +: DW] = xin[r][x][DW-1:0];
            in_valid = 1'b1;
            mode = (r == 0) ? md : (flip ? ~md : md);
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: row %0d in_ready never rose", r);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Collects N beats into yout, checking stall stability, in_ready and out_last
    task automatic recv_frame(input logic stall, input logic garbage);
        int k = 0;
        int cyc = 0;
        logic rdy;
        logic have_prev = 1'b0;
        logic [N*DW-1:0] prev_col = '0;
        logic prev_last = 1'b0;
        while (k < N && cyc < 300) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_col: got %b want 0 (beat %0d)", in_ready, k);
            end
            if (have_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_col !== prev_col || out_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid %b last %b col %h, want 1 %b %h",
                             out_valid, out_last, out_col, prev_last, prev_col);
                end
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (garbage) begin
                in_valid = 1'b1;
                in_row = {N{$urandom}};
            end
            if (out_valid === 1'b1 && rdy) begin
                for (int u = 0; u < N; u++) yout[u][k] = longint'($signed(out_col[u*DW +: DW]));
                n_checks++;
                if (out_last !== 1'(k == N - 1)) begin
                    n_fail++;
                    $display("FAIL out_last: beat %0d got %b want %b", k, out_last, (k == N - 1));
                end
                k++;
            end
            have_prev = (out_valid === 1'b1) && !rdy;
            prev_col  = out_col;
            prev_last = out_last;
            cyc++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (k < N) begin
            n_fail++;
            $display("FAIL recv_timeout: got %0d beats want %0d", k, N);
        end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL return_to_row: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic check_dc_only(input string name, input longint dc);
        for (int u = 0; u < N; u++)
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (yout[u][k] !== ((u == 0 && k == 0) ? dc : 64'sd0)) begin
                    n_fail++;
                    $display("FAIL %s: Y[%0d][%0d] got %0d want %0d", name, u, k, yout[u][k],
                             (u == 0 && k == 0) ? dc : 64'sd0);
                end
            end
    endtask

    task automatic check_model(input string name);
        for (int u = 0; u < N; u++)
            for (int k = 0; k < N; k++) begin
                n_checks++;
                if (yout[u][k] !== ymod[u][k]) begin
                    n_fail++;
                    $display("FAIL %s: Y[%0d][%0d] got %0d want %0d", name, u, k, yout[u][k], ymod[u][k]);
                end
            end
    endtask

    task automatic fill_const(input longint v);
        for (int r = 0; r < N; r++) for (int x = 0; x < N; x++) xin[r][x] = v;
    endtask

    task automatic fill_rand(input int span);
        for (int r = 0; r < N; r++)
            for (int x = 0; x < N; x++)
                xin[r][x] = longint'($urandom_range(0, 2 * span - 1)) - span;
    endtask

    task automatic test_reset;
        reset = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || out_col !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy %b vld %b last %b col %h want 0 0 0 0",
                     in_ready, out_valid, out_last, out_col);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero;
        fill_const(0);
        send_rows(1'b0, 1'b0, N);
        recv_frame(1'b0, 1'b0);
        check_dc_only("zero_frame", 0);
    endtask

    // Constant 100 gives DC 800; mode flipped after row 0 must not matter
    task automatic test_const_mode_flip;
        fill_const(100);
        send_rows(1'b0, 1'b1, N);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: out_valid %b in_ready %b want 0 0", out_valid, in_ready);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid %b want 1 two cycles after last row", out_valid);
        end
        recv_frame(1'b0, 1'b0);
        check_dc_only("const100", 800);
    endtask

    task automatic test_random_stall;
        fill_rand(32768);
        model(1'b0);
        send_rows(1'b0, 1'b0, N);
        recv_frame(1'b1, 1'b1);
        check_model("random_stall");
    endtask

    task automatic test_back_to_back;
        fill_rand(32768);
        model(1'b1);
        send_rows(1'b1, 1'b0, N);
        recv_frame(1'b1, 1'b0);
        check_model("inverse_b2b");
    endtask

    task automatic test_roundtrip;
        longint d;
        fill_rand(128);
        orig = xin;
        send_rows(1'b0, 1'b0, N);
        recv_frame(1'b0, 1'b0);
        xin = yout;
        send_rows(1'b1, 1'b0, N);
        recv_frame(1'b0, 1'b0);
        for (int u = 0; u < N; u++)
            for (int k = 0; k < N; k++) begin
                d = yout[u][k] - orig[u][k];
                n_checks++;
                if (d < -2 || d > 2) begin
                    n_fail++;
                    $display("FAIL roundtrip: X[%0d][%0d] got %0d want %0d +/-2", u, k, yout[u][k], orig[u][k]);
                end
            end
    endtask

    task automatic test_mid_reset;
        fill_rand(1000);
        send_rows(1'b0, 1'b0, 5);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ready: in_ready %b want 0", in_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 2 * N + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_valid: out_valid %b want 0 at cycle %0d", out_valid, i);
            end
        end
        fill_const(100);
        send_rows(1'b0, 1'b0, N);
        recv_frame(1'b0, 1'b0);
        check_dc_only("after_reset", 800);
    endtask

    task automatic test_saturation;
        for (int r = 0; r < N; r++)
            for (int x = 0; x < N; x++)
                xin[r][x] = ((r + x) % 2 == 0) ? SMAX : -SMAX;
        model(1'b0);
        send_rows(1'b0, 1'b0, N);
        recv_frame(1'b0, 1'b0);
        check_model("saturation");
        n_checks++;
        if (yout[7][7] !== SMAX) begin
            n_fail++;
            $display("FAIL sat_corner: Y[7][7] got %0d want %0d", yout[7][7], SMAX);
        end
        n_checks++;
        if (yout[0][0] !== 0) begin
            n_fail++;
            $display("FAIL sat_dc: Y[0][0] got %0d want 0", yout[0][0]);
        end
    endtask

    initial begin
        init_coefs();
        test_reset();
        test_zero();
        test_const_mode_flip();
        test_random_stall();
        test_back_to_back();
        test_roundtrip();
        test_mid_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dct_2d_nxn_stream.md
DCT_2D_NXN_STREAM -- requirements
Module: dct_2d_nxn_stream

Interface
REQ-001 SHALL have parameter N, default 8, meaning block dimension; legal values 4, 8, 16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning signed sample/coefficient width per lane.
REQ-003 SHALL have parameter COEF_FRAC, default 14, meaning fractional bits of the fixed-point cosine table.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: mode  in  1  0 = forward DCT, 1 = inverse DCT; sampled on first accepted beat of a frame.
REQ-007 SHALL have ports: in_valid  in  1 / in_ready  out  1  input row handshake.
REQ-008 SHALL have ports: in_row  in  N*DATA_WIDTH  one input row; lane j at bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have ports: out_valid  out  1 / out_ready  in  1  output beat handshake.
REQ-010 SHALL have ports: out_col  out  N*DATA_WIDTH  one output column; lane u = Y[u][k] for beat k.
REQ-011 SHALL have ports: out_last  out  1  high on beat k = N-1 only.

Function
REQ-012 SHALL define C[u][x] = a(u)*cos((2x+1)*u*pi/(2N)), a(0)=sqrt(1/N), else sqrt(2/N), stored as round-half-away(C*2^COEF_FRAC), signed.
REQ-013 SHALL compute forward Y = C*X*C^T, inverse X = C^T*Y*C, with X[r][x] = lane x of input row r.
REQ-014 SHALL use matrix M[k][j] = C[k][j] (forward) or C[j][k] (inverse) for both passes: out[k] = sum_j in[j]*M[k][j].
REQ-015 SHALL accumulate at full precision, add 2^(COEF_FRAC-1), arithmetic-shift right COEF_FRAC, saturate to signed DATA_WIDTH; applied after each pass.
REQ-016 SHALL run FSM states ROW, COL; reset enters ROW.
REQ-017 In ROW: in_ready=1; each handshake (in_valid&in_ready) writes the row-pass result of that row into transpose buffer row r, r incrementing 0..N-1.
REQ-018 SHALL transition ROW->COL on the cycle after the handshake with r=N-1; in_ready=0 throughout COL.
REQ-019 In COL: column k (k=0..N-1) of the buffer is transformed and registered into out_col; out_valid asserts one cycle after COL entry.
REQ-020 out_col/out_valid/out_last SHALL hold stable while out_valid&!out_ready; next column loads on the cycle after out_valid&out_ready.
REQ-021 After the beat k=N-1 is accepted, SHALL return to ROW with r=0, in_ready=1 on the next cycle; no frame overlap.
REQ-022 mode SHALL be latched at the r=0 handshake and used for both passes of that frame; mode changes mid-frame have no effect.
REQ-023 in_valid while in_ready=0 SHALL be ignored; no data lost or duplicated.
REQ-024 Latency: first out_valid 2 cycles after the r=N-1 handshake; throughput 1 frame per >= 2N+1 cycles.

Reset
REQ-025 On reset: state ROW, r=0, k=0, in_ready=0 during reset cycle then 1, out_valid=0, out_last=0, out_col=0, latched mode=0.
REQ-026 Reset mid-frame SHALL discard the partial frame and buffer contents; no output beat emitted for it.

Structure
REQ-027 Package dct_pkg SHALL hold the coefficient-generation function C(N,COEF_FRAC,u,x), state enum, and rounding/saturation function.
REQ-028 One sub-module dct_1d_lane SHALL implement the N-point matrix-vector product with mode-selected M, rounding and saturation; instantiated once, shared by both passes via input mux.
REQ-029 Transpose buffer SHALL be N*N*DATA_WIDTH registers, written by row, read by column.

Verification
REQ-030 All-zero frame, forward, N=8 -> 8 beats of all-zero out_col, out_last on beat 7 only.
REQ-031 Constant 100 frame, forward, N=8, COEF_FRAC=14 -> Y[0][0]=800, all other 63 outputs 0.
REQ-032 Random frame with out_ready toggled 50% random -> outputs identical to golden model, stable during stalls, in_ready=0 for entire COL phase.
REQ-033 Forward then inverse (outputs re-fed column-major transposed into rows) of random 8-bit samples -> reconstruction within +/-2 of original.
REQ-034 Reset asserted after 5 rows accepted -> out_valid stays 0; next full frame of constant 100 yields Y[0][0]=800.
REQ-035 Inputs of +/-(2^(DATA_WIDTH-1)-1) checkerboard -> outputs saturate to signed DATA_WIDTH limits, no wrap.
